// File: rtl/borrow_skip_subtractor_seq.sv
// Sequential a - b - bin, one BLOCK-bit slice per cycle; the borrow bypasses slices where a == b.
// Latency N+1 edges from accepted start to done; start is ignored while busy (no backpressure otherwise).
module borrow_skip_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              bin,
    output logic                              busy,
    output logic                              done,
    output logic [WIDTH-1:0]                  diff,
    output logic                              bout,
    output logic [$clog2(WIDTH/BLOCK):0]      skip_count
);

    localparam int N  = WIDTH / BLOCK;
    localparam int CW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0] diff_q;
    logic             br_q, bout_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    skip_q, skip_d, skip_cnt_q;

    logic [BLOCK-1:0]       slice_a, slice_b, slice_d;
    logic [WIDTH+BLOCK-1:0] res_cat;
    logic                   br, rip_bout, prop, slice_bout;
    logic                   accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (idx_q == IW'(N - 1));

    // Operands shift right each cycle, so the active slice is always the low BLOCK bits.
    always_comb begin
        slice_a  = a_q[BLOCK-1:0];
        slice_b  = b_q[BLOCK-1:0];
        slice_d  = '0;
        br       = br_q;
        for (int j = 0; j < BLOCK; j++) begin
            slice_d[j] = slice_a[j] ^ slice_b[j] ^ br;
            br         = (~slice_a[j] & slice_b[j]) | (~(slice_a[j] ^ slice_b[j]) & br);
        end
        rip_bout   = br;
        prop       = &(~(slice_a ^ slice_b));
        slice_bout = prop ? br_q : rip_bout;
        skip_d     = skip_q + CW'(prop);
        res_cat    = {slice_d, res_q};
        res_d      = res_cat[WIDTH+BLOCK-1:BLOCK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            br_q       <= 1'b0;
            idx_q      <= '0;
            skip_q     <= '0;
            res_q      <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            skip_cnt_q <= '0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            br_q   <= bin;
            idx_q  <= '0;
            skip_q <= '0;
            res_q  <= '0;
        end else if (state_q == RUN) begin
            a_q    <= a_q >> BLOCK;
            b_q    <= b_q >> BLOCK;
            br_q   <= slice_bout;
            idx_q  <= idx_q + IW'(1);
            skip_q <= skip_d;
            res_q  <= res_d;
            // Visible results move only on the edge that enters DONE.
            if (last) begin
                diff_q     <= res_d;
                bout_q     <= slice_bout;
                skip_cnt_q <= skip_d;
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign bout       = bout_q;
    assign skip_count = skip_cnt_q;

endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Bench for borrow_skip_subtractor_seq (WIDTH=16, BLOCK=4): directed vectors plus random triples.
module tb_borrow_skip_subtractor_seq;

    localparam int W  = 16;
    localparam int BL = 4;
    localparam int N  = W / BL;

    logic          clk = 1'b0;
    logic          rst_n, start, bin;
    logic [W-1:0]  a, b;
    logic          busy, done, bout;
    logic [W-1:0]  diff;
    logic [2:0]    skip_count;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic [2:0]   sk;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    exp_t cmp_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    borrow_skip_subtractor_seq #(.WIDTH(W), .BLOCK(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .bout       (bout),
        .skip_count (skip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: signed integer difference and slice equality count.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   t;
        t    = int'(av) - int'(bv) - int'(bi);
        e.d  = t[W-1:0];
        e.bo = (t < 0);
        e.sk = '0;
        for (int s = 0; s < N; s++)
            if (av[BL*s +: BL] == bv[BL*s +: BL]) e.sk = e.sk + 3'd1;
        return e;
    endfunction

    // Drive a start; returns 1 time unit after the accept edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        @(negedge clk);
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("done_timeout", 32'(done), 32'(1));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_e.d  = '0;
            last_e.bo = 1'b0;
            last_e.sk = '0;
        end else if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 required=0");
            end else begin
                cmp_e = exp_q.pop_front();
                chk("diff", 32'(diff), 32'(cmp_e.d));
                chk("bout", 32'(bout), 32'(cmp_e.bo));
                chk("skip_count", 32'(skip_count), 32'(cmp_e.sk));
                last_e = cmp_e;
            end
        end else begin
            chk("hold_diff", 32'(diff), 32'(last_e.d));
            chk("hold_bout", 32'(bout), 32'(last_e.bo));
            chk("hold_skip", 32'(skip_count), 32'(last_e.sk));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        int         edges, bcyc, dc;
        logic [W-1:0] av, bv;
        logic       bi;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;

        // Model pinned against hand-worked values.
        e = model(16'h1234, 16'h0234, 1'b0);
        chk("model_partial_d", 32'(e.d), 32'h1000);
        chk("model_partial_sk", 32'(e.sk), 32'd3);
        e = model(16'h0000, 16'h0001, 1'b0);
        chk("model_under_d", 32'(e.d), 32'hFFFF);
        chk("model_under_bo", 32'(e.bo), 32'd1);
        e = model(16'hABCD, 16'h1234, 1'b0);
        chk("model_noskip_d", 32'(e.d), 32'h9999);
        chk("model_noskip_sk", 32'(e.sk), 32'd0);

        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_bout", 32'(bout), 32'(0));
        chk("rst_skip", 32'(skip_count), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial skip
        issue(16'h1234, 16'h0234, 1'b0);
        wait_done(edges, bcyc);
        chk("partial_latency", 32'(edges), 32'(N));
        chk("partial_busy_cycles", 32'(bcyc), 32'(N));
        chk("partial_diff_lit", 32'(diff), 32'h1000);
        chk("partial_skip_lit", 32'(skip_count), 32'd3);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));

        // Underflow
        issue(16'h0000, 16'h0001, 1'b0);
        wait_done(edges, bcyc);
        chk("under_diff_lit", 32'(diff), 32'hFFFF);
        chk("under_bout_lit", 32'(bout), 32'd1);
        chk("under_skip_lit", 32'(skip_count), 32'd3);
        @(negedge clk);

        // Full skip with borrow-in
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(edges, bcyc);
        chk("full_diff_lit", 32'(diff), 32'hFFFF);
        chk("full_bout_lit", 32'(bout), 32'd1);
        chk("full_skip_lit", 32'(skip_count), 32'd4);
        @(negedge clk);

        // No skip, with start held high through RUN
        dc = done_cnt;
        issue(16'hABCD, 16'h1234, 1'b0);
        a     = '0;
        b     = '0;
        start = 1'b1;
        repeat (N) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("noskip_done", 32'(done), 32'(1));
        chk("noskip_diff_lit", 32'(diff), 32'h9999);
        chk("noskip_bout_lit", 32'(bout), 32'd0);
        chk("noskip_skip_lit", 32'(skip_count), 32'd0);
        repeat (6) @(negedge clk);
        chk("noskip_done_count", 32'(done_cnt - dc), 32'(1));

        // Reset mid-operation
        dc = done_cnt;
        issue(16'h0000, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_diff", 32'(diff), 32'(0));
        chk("midrst_bout", 32'(bout), 32'(0));
        chk("midrst_skip", 32'(skip_count), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - dc), 32'(0));

        // Back-to-back: start issued in the DONE cycle
        issue(16'h8000, 16'h0001, 1'b1);
        wait_done(edges, bcyc);
        issue(16'h1111, 16'h2222, 1'b0);
        wait_done(edges, bcyc);
        chk("b2b_latency", 32'(edges), 32'(N));
        chk("b2b_diff_lit", 32'(diff), 32'hEEEF);
        chk("b2b_bout_lit", 32'(bout), 32'd1);

        // Random triples, biased so some slices match
        for (int i = 0; i < 1000; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            for (int s = 0; s < N; s++)
                if ($urandom_range(0, 1) == 1) bv[BL*s +: BL] = av[BL*s +: BL];
            bi = 1'($urandom_range(0, 1));
            issue(av, bv, bi);
            wait_done(edges, bcyc);
            chk("rand_latency", 32'(edges), 32'(N));
            if (i % 3 != 0) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
